// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: opcode/funct constants, instruction field
// layout and the fetch FSM state type.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ALT   = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam int unsigned OPC_HI   = 31;
  localparam int unsigned OPC_LO   = 26;
  localparam int unsigned RS_HI    = 25;
  localparam int unsigned RS_LO    = 21;
  localparam int unsigned RT_HI    = 20;
  localparam int unsigned RT_LO    = 16;
  localparam int unsigned RD_HI    = 15;
  localparam int unsigned RD_LO    = 11;
  localparam int unsigned SHAMT_HI = 10;
  localparam int unsigned SHAMT_LO = 6;
  localparam int unsigned FUNCT_HI = 5;
  localparam int unsigned FUNCT_LO = 0;
  localparam int unsigned IMM_HI   = 15;
  localparam int unsigned IMM_LO   = 0;

  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
  } instr_fields_t;

  function automatic instr_fields_t split_instr(input logic [31:0] w);
    instr_fields_t f;
    f.opcode = w[OPC_HI:OPC_LO];
    f.rs     = w[RS_HI:RS_LO];
    f.rt     = w[RT_HI:RT_LO];
    f.rd     = w[RD_HI:RD_LO];
    f.shamt  = w[SHAMT_HI:SHAMT_LO];
    f.funct  = w[FUNCT_HI:FUNCT_LO];
    f.imm    = w[IMM_HI:IMM_LO];
    return f;
  endfunction

endpackage

// File: rtl/instr_fetch_obuf.sv
// Two-entry head+skid output buffer between instruction fetch and decode.
// The head register drives decode directly; the skid absorbs one word of backpressure.
module fetch_obuf
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [31:0]       in_word,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_pc,
  output logic              skid_full
);

  logic [31:0]       skid_word;
  logic [ADDR_W-1:0] skid_pc;
  logic              pop;

  assign pop = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_pc    <= '0;
      skid_full <= 1'b0;
      skid_word <= '0;
      skid_pc   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (!out_valid || pop) begin
      if (skid_full) begin
        // Skid is older than any incoming word, so it always moves up first.
        out_valid <= 1'b1;
        out_word  <= skid_word;
        out_pc    <= skid_pc;
        skid_full <= in_valid;
        if (in_valid) begin
          skid_word <= in_word;
          skid_pc   <= in_pc;
        end
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_word <= in_word;
          out_pc   <= in_pc;
        end
      end
    end else if (in_valid) begin
      skid_full <= 1'b1;
      skid_word <= in_word;
      skid_pc   <= in_pc;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC and fetch FSM driving an imem req/ack port, with
// decoded MIPS fields presented to decode through a two-entry output buffer.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target;
  logic              accept;
  logic              head_pop;
  logic              skid_full;
  logic [31:0]       head_word;
  instr_fields_t     fields;

  assign head_pop  = dec_valid && dec_ready;
  assign accept    = (state == ST_REQ) && imem_ack && !redirect_valid;
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      target   <= '0;
      imem_req <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_REQ;
          imem_req <= 1'b1;
          if (redirect_valid) pc <= redirect_pc;
        end
        ST_REQ: begin
          if (redirect_valid) begin
            if (imem_ack) begin
              pc <= redirect_pc;
            end else begin
              target <= redirect_pc;
              state  <= ST_DRAIN;
            end
          end else if (imem_ack) begin
            pc <= pc + ADDR_W'(PC_STEP);
            // Word lands in skid exactly when the head is held this cycle.
            if (dec_valid && !dec_ready) begin
              state    <= ST_HOLD;
              imem_req <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            pc       <= redirect_pc;
            state    <= ST_REQ;
            imem_req <= 1'b1;
          end else if (!skid_full || head_pop) begin
            state    <= ST_REQ;
            imem_req <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            pc    <= redirect_valid ? redirect_pc : target;
            state <= ST_REQ;
          end else if (redirect_valid) begin
            target <= redirect_pc;
          end
        end
        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  fetch_obuf #(
    .ADDR_W(ADDR_W)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .in_valid  (accept),
    .in_word   (imem_rdata),
    .in_pc     (pc),
    .out_ready (dec_ready),
    .out_valid (dec_valid),
    .out_word  (head_word),
    .out_pc    (dec_pc),
    .skid_full (skid_full)
  );

  assign fields = split_instr(head_word);
  assign opcode = fields.opcode;
  assign rs     = fields.rs;
  assign rt     = fields.rt;
  assign rd     = fields.rd;
  assign shamt  = fields.shamt;
  assign funct  = fields.funct;
  assign imm    = fields.imm;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: transaction-level fetch/queue model plus
// directed scenarios with hand-computed expectations.
module tb_instr_fetch;

  localparam logic [31:0] FIXED_WORD = 32'h012A4020;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_pc;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory behaviour: ack tied high, or ack after ack_lat waiting cycles.
  bit          ack_tied   = 1'b1;
  int unsigned ack_lat    = 0;
  bit          fixed_word = 1'b1;
  int unsigned cnt        = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        q[$];
  logic [31:0] fp = '0;
  logic [31:0] tgt = '0;
  bit          draining = 1'b0;

  instr_fetch #(
    .ADDR_W  (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_pc        (dec_pc),
    .opcode        (opcode),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .shamt         (shamt),
    .funct         (funct),
    .imm           (imm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return fixed_word ? FIXED_WORD : {6'b001000, 5'd1, 5'd2, a[15:0]};
  endfunction

  // Model: queue of words owed to decode, fetch pointer, pending redirect target.
  always @(negedge clk) begin
    logic ack, hs;
    if (!rst_n) begin
      q.delete();
      fp       = 32'h0;
      tgt      = 32'h0;
      draining = 1'b0;
      cnt      = 0;
      imem_ack = ack_tied;
    end else begin
      ack = ack_tied ? 1'b1 : (imem_req && cnt == ack_lat);
      if (ack || !imem_req) cnt = 0;
      else cnt++;
      imem_ack   = ack;
      imem_rdata = word_of(imem_addr);

      chk("dec_valid", dec_valid, q.size() != 0);
      if (imem_req) chk("imem_addr", imem_addr, fp);
      if (q.size() == 2) chk("req_when_full", imem_req, 1'b0);
      if (dec_valid && q.size() != 0) begin
        chk("dec_pc", dec_pc, q[0].pc);
        chk("fields", {opcode, rs, rt, rd, shamt, funct, imm},
            {q[0].word[31:26], q[0].word[25:21], q[0].word[20:16], q[0].word[15:11],
             q[0].word[10:6], q[0].word[5:0], q[0].word[15:0]});
      end

      hs = imem_req && ack;
      if (redirect_valid) begin
        q.delete();
        if (hs || !imem_req) begin
          fp       = redirect_pc;
          draining = 1'b0;
        end else begin
          draining = 1'b1;
          tgt      = redirect_pc;
        end
      end else begin
        if (dec_valid && dec_ready && q.size() != 0) void'(q.pop_front());
        if (hs) begin
          if (draining) begin
            fp       = tgt;
            draining = 1'b0;
          end else begin
            q.push_back('{fp, imem_rdata});
            fp = fp + 32'd4;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", dec_valid, 1'b0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_fields", {opcode, rs, rt, rd, shamt, funct, imm}, 48'h0);
  endtask

  // Called just after a rising edge; returns with rst_n freshly released.
  task automatic do_reset(input bit tied, input int unsigned lat, input bit fixed);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check_reset_outputs();
    ack_tied   = tied;
    ack_lat    = lat;
    fixed_word = fixed;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int times[$];

    tick();

    // Streaming with ack tied high and decode always ready.
    dec_ready = 1'b1;
    do_reset(1'b1, 0, 1'b1);
    chk("A_req_first_cycle", imem_req, 1'b0);
    tick();
    chk("A_req_second_cycle", imem_req, 1'b1);
    chk("A_addr0", imem_addr, 32'h0);
    tick();
    chk("A_addr4", imem_addr, 32'h4);
    chk("A_valid", dec_valid, 1'b1);
    chk("A_dec_pc0", dec_pc, 32'h0);
    chk("A_opcode", opcode, 6'd0);
    chk("A_rs", rs, 5'd9);
    chk("A_rt", rt, 5'd10);
    chk("A_rd", rd, 5'd8);
    chk("A_funct", funct, 6'h20);
    tick();
    chk("A_addr8", imem_addr, 32'h8);
    chk("A_dec_pc4", dec_pc, 32'h4);
    n = 0;
    repeat (10) begin
      tick();
      if (dec_valid) n++;
    end
    chk("A_throughput", n, 10);

    // Backpressure: head and skid fill, fetch stops, order preserved on release.
    dec_ready = 1'b0;
    do_reset(1'b1, 0, 1'b0);
    repeat (4) tick();
    chk("B_req_stalled", imem_req, 1'b0);
    chk("B_valid_held", dec_valid, 1'b1);
    chk("B_pc_held", dec_pc, 32'h0);
    tick();
    chk("B_req_stalled2", imem_req, 1'b0);
    chk("B_pc_held2", dec_pc, 32'h0);
    dec_ready = 1'b1;
    tick();
    chk("B_pc4", dec_pc, 32'h4);
    chk("B_req_resume", imem_req, 1'b1);
    chk("B_addr8", imem_addr, 32'h8);
    tick();
    chk("B_pc8", dec_pc, 32'h8);
    repeat (4) tick();

    // Three-cycle ack latency: one instruction every four cycles.
    dec_ready = 1'b1;
    do_reset(1'b0, 3, 1'b0);
    times.delete();
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (dec_valid) times.push_back(t);
    end
    chk("C_count", times.size(), 7);
    if (times.size() >= 2) begin
      chk("C_first_latency", times[0], 5);
      chk("C_period", times[1] - times[0], 4);
    end

    // Redirect while the fetch of 0x8 is outstanding; target overwritten in DRAIN.
    dec_ready = 1'b1;
    do_reset(1'b0, 3, 1'b0);
    for (int i = 0; i < 20 && !(imem_req && imem_addr == 32'h8); i++) tick();
    chk("D_reach8", imem_addr, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    chk("D_drain_req", imem_req, 1'b1);
    chk("D_drain_addr", imem_addr, 32'h8);
    chk("D_flush_valid", dec_valid, 1'b0);
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("D_drain_addr2", imem_addr, 32'h8);
    for (int i = 0; i < 10 && imem_addr == 32'h8; i++) tick();
    chk("D_redirect_addr", imem_addr, 32'h100);
    chk("D_no_valid", dec_valid, 1'b0);
    for (int i = 0; i < 10 && !dec_valid; i++) tick();
    chk("D_first_pc", dec_pc, 32'h100);
    repeat (3) tick();

    // Redirect coinciding with an ack while the head is held; PC wraps.
    dec_ready = 1'b0;
    do_reset(1'b1, 0, 1'b0);
    tick();
    tick();
    chk("E_head_full", dec_valid, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("E_flushed", dec_valid, 1'b0);
    chk("E_req", imem_req, 1'b1);
    chk("E_addr_target", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("E_valid_top", dec_valid, 1'b1);
    chk("E_pc_top", dec_pc, 32'hFFFF_FFFC);
    chk("E_wrap_addr", imem_addr, 32'h0);
    dec_ready = 1'b1;
    repeat (5) tick();

    // Reset pulsed in the middle of DRAIN.
    dec_ready = 1'b1;
    do_reset(1'b0, 3, 1'b0);
    for (int i = 0; i < 20 && !(imem_req && imem_addr == 32'h4); i++) tick();
    chk("F_reach4", imem_addr, 32'h4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    chk("F_drain_req", imem_req, 1'b1);
    chk("F_drain_addr", imem_addr, 32'h4);
    tick();
    do_reset(1'b1, 0, 1'b0);
    chk("F_req_after_reset", imem_req, 1'b0);
    tick();
    chk("F_restart_req", imem_req, 1'b1);
    chk("F_restart_addr", imem_addr, 32'h0);
    tick();
    chk("F_first_pc", dec_pc, 32'h0);
    chk("F_first_valid", dec_valid, 1'b1);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
